// File: rtl/ordering_unpack_pkg.sv
// Shared types and constants for the ordering load deserializer.
// Holds the default tour size, the beat type and a helper that gives the
// number of valid slots in the final (possibly partial) beat.
package ordering_unpack_pkg;

  localparam int city_num     = 31;
  localparam int city_num_log = 5;
  localparam int city_w       = 8;

  // One host beat: eight city indices, slot 7 carries the first city.
  typedef logic [7:0][city_w-1:0] ordering_beat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } unpack_state_e;

  // Number of meaningful slots in the last beat of an n-city tour.
  function automatic int last_beat_slots(input int n);
    return ((n % 8) == 0) ? 8 : (n % 8);
  endfunction

endpackage

// File: rtl/ordering_unpack_if.sv
// Host beat stream plus the ordering RAM write port.
// The master side drives beats and observes writes; the slave side is the
// deserializer, which consumes beats and produces RAM writes.
interface ordering_unpack_if
  import ordering_unpack_pkg::*;
#(
  parameter int CITY_NUM_LOG = city_num_log
);

  logic                    ordering_in_valid;
  ordering_beat_t          ordering_in_data;
  logic                    wr_en;
  logic [CITY_NUM_LOG-1:0] wr_addr;
  logic [city_w-1:0]       wr_data;

  modport master (
    output ordering_in_valid,
    output ordering_in_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  ordering_in_valid,
    input  ordering_in_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/ordering_unpack_beat_fifo.sv
// Beat FIFO for the ordering deserializer: DEPTH entries of W bits,
// combinational head, synchronous clear, asynchronous active-low reset.
// The depth equals the beats per tour, so the producer never overruns it.
module ordering_unpack_beat_fifo
  import ordering_unpack_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8 * city_w
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);

  // Storage array: data only, written on push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy bookkeeping; clear drops all contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ordering_unpack.sv
// Receive-side deserializer for the host ordering load stream.
// Buffers 8-city beats and writes one city per cycle into the ordering RAM,
// slot 7 first, with a done pulse after the last tour position.
// Optional macro ORDERING_CHECK_EN adds a permutation checker driving perm_err.
module ordering_unpack
  import ordering_unpack_pkg::*;
#(
  parameter int CITY_NUM     = city_num,
  parameter int CITY_NUM_LOG = city_num_log,
  parameter int BEAT_NUM     = (CITY_NUM + 7) / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  ordering_unpack_if.slave        ord,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic                    perm_err
);

  localparam int BCW       = $clog2(BEAT_NUM + 1);
  localparam int LAST_SLOT = 8 - last_beat_slots(CITY_NUM);
  localparam logic [CITY_NUM_LOG-1:0] LAST_ADDR = CITY_NUM_LOG'(CITY_NUM - 1);

  unpack_state_e           state_q;
  logic [BCW-1:0]          beats_in_q, beats_out_q;
  logic [2:0]              slot_q;
  logic [CITY_NUM_LOG-1:0] addr_q;
  logic                    fin_q;
  logic                    wr_en_q;
  logic [CITY_NUM_LOG-1:0] wr_addr_q;
  logic [city_w-1:0]       wr_data_q;
  logic                    busy_q, done_q, ovf_q;

  logic           arm_d, accept_d, drop_d, emit_d, pop_d, fifo_empty;
  ordering_beat_t head;

  // Beat accept/drop, emission and pop decisions for this cycle.
  always_comb begin
    arm_d    = start && (state_q == ST_IDLE);
    accept_d = ord.ordering_in_valid && (state_q == ST_RUN) &&
               (beats_in_q < BCW'(BEAT_NUM));
    drop_d   = ord.ordering_in_valid && !accept_d;
    emit_d   = (state_q == ST_RUN) && !fin_q && !fifo_empty;
    // The head leaves after slot 0, or after the last real slot of the final beat.
    pop_d    = emit_d && ((slot_q == 3'd0) ||
               ((beats_out_q == BCW'(BEAT_NUM - 1)) && (slot_q == 3'(LAST_SLOT))));
  end

  ordering_unpack_beat_fifo #(
    .DEPTH (BEAT_NUM),
    .W     (8 * city_w)
  ) u_beat_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (arm_d),
    .push  (accept_d),
    .din   (ord.ordering_in_data),
    .pop   (pop_d),
    .dout  (head),
    .empty (fifo_empty)
  );

  // Load FSM with registered RAM write port and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      beats_in_q  <= '0;
      beats_out_q <= '0;
      slot_q      <= 3'd7;
      addr_q      <= '0;
      fin_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      if (arm_d) begin
        state_q     <= ST_RUN;
        busy_q      <= 1'b1;
        beats_in_q  <= '0;
        beats_out_q <= '0;
        slot_q      <= 3'd7;
        addr_q      <= '0;
        fin_q       <= 1'b0;
        ovf_q       <= 1'b0;
      end else if (state_q == ST_RUN) begin
        if (fin_q) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          fin_q   <= 1'b0;
        end
        if (accept_d) beats_in_q <= beats_in_q + BCW'(1);
        if (emit_d) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr_q;
          wr_data_q <= head[slot_q];
          addr_q    <= addr_q + CITY_NUM_LOG'(1);
          if (addr_q == LAST_ADDR) fin_q <= 1'b1;
          if (pop_d) begin
            slot_q      <= 3'd7;
            beats_out_q <= beats_out_q + BCW'(1);
          end else begin
            slot_q <= slot_q - 3'd1;
          end
        end
      end
      // A dropped beat wins over the clear done by start in the same cycle.
      if (drop_d) ovf_q <= 1'b1;
    end
  end

  assign ord.wr_en   = wr_en_q;
  assign ord.wr_addr = wr_addr_q;
  assign ord.wr_data = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ovf         = ovf_q;

`ifdef ORDERING_CHECK_EN
  logic [CITY_NUM-1:0] seen_q;
  logic [CITY_NUM-1:0] hit_d;
  logic                bad_d;
  logic                perm_q;

  // Classify the write issued last cycle; out-of-range cities shift out to zero.
  always_comb begin
    hit_d = CITY_NUM'(1) << wr_data_q;
    bad_d = (int'(wr_data_q) >= CITY_NUM) || (|(seen_q & hit_d)) ||
            ((wr_addr_q == '0) && (wr_data_q != '0));
  end

  // Seen-bitmap and sticky error, both cleared when a load is armed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_q <= '0;
      perm_q <= 1'b0;
    end else if (arm_d) begin
      seen_q <= '0;
      perm_q <= 1'b0;
    end else if (wr_en_q) begin
      seen_q <= seen_q | hit_d;
      if (bad_d) perm_q <= 1'b1;
    end
  end

  assign perm_err = perm_q;
`else
  assign perm_err = 1'b0;
`endif

endmodule

// File: tb/tb_ordering_unpack.sv
// Bench for ordering_unpack: a city-queue model of the load, compared every
// cycle, plus directed literal timing checks and randomized tours.
module tb_ordering_unpack;
  import ordering_unpack_pkg::*;

  localparam int CN  = 31;
  localparam int BN  = 4;
  localparam int CN2 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start2;
  logic busy, done, ovf, perm_err;
  logic busy2, done2, ovf2, perm2;

  int n_chk = 0;
  int n_fail = 0;

  ordering_unpack_if #(.CITY_NUM_LOG(5)) bus ();
  ordering_unpack_if #(.CITY_NUM_LOG(5)) bus2 ();

  ordering_unpack #(.CITY_NUM(CN), .CITY_NUM_LOG(5)) dut (
    .clk(clk), .reset(rst_n), .start(start), .ord(bus.slave),
    .busy(busy), .done(done), .ovf(ovf), .perm_err(perm_err)
  );

  ordering_unpack #(.CITY_NUM(CN2), .CITY_NUM_LOG(5)) dut32 (
    .clk(clk), .reset(rst_n), .start(start2), .ord(bus2.slave),
    .busy(busy2), .done(done2), .ovf(ovf2), .perm_err(perm2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: a queue of cities ----------------
  int             cyc = 0;
  int             start_edge = 0;
  bit             m_run = 0, m_fin = 0;
  int             m_beats = 0, m_pushed = 0, m_addr = 0;
  logic [7:0]     mq[$];
  logic           e_en = 0, e_busy = 0, e_done = 0, e_ovf = 0, e_perm = 0;
  logic [4:0]     e_addr = '0;
  logic [7:0]     e_data = '0;
`ifdef ORDERING_CHECK_EN
  bit [255:0]     m_seen = '0;
  logic           p_en;
  logic [4:0]     p_addr;
  logic [7:0]     p_data;
`endif

  initial begin : model
    bit run_b, arm;
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        m_run = 0; m_fin = 0; m_beats = 0; m_pushed = 0; m_addr = 0;
        mq.delete();
        e_en = 0; e_addr = '0; e_data = '0; e_busy = 0; e_done = 0; e_ovf = 0; e_perm = 0;
`ifdef ORDERING_CHECK_EN
        m_seen = '0;
`endif
      end else begin
        cyc++;
        run_b = m_run;
`ifdef ORDERING_CHECK_EN
        p_en = e_en; p_addr = e_addr; p_data = e_data;
        if (p_en) begin
          if (p_data >= CN || m_seen[p_data] || (p_addr == 0 && p_data != 0)) e_perm = 1;
          m_seen[p_data] = 1'b1;
        end
`endif
        e_en = 0;
        e_done = 0;
        if (run_b) begin
          if (m_fin) begin
            m_run = 0; m_fin = 0; e_busy = 0; e_done = 1;
          end else if (mq.size() > 0) begin
            e_en = 1;
            e_addr = 5'(m_addr);
            e_data = mq.pop_front();
            if (m_addr == CN - 1) m_fin = 1;
            m_addr++;
          end
        end
        arm = !run_b && (start === 1'b1);
        if (arm) begin
          m_run = 1; e_busy = 1; mq.delete();
          m_beats = 0; m_pushed = 0; m_addr = 0; m_fin = 0;
          e_ovf = 0; e_perm = 0; start_edge = cyc;
`ifdef ORDERING_CHECK_EN
          m_seen = '0;
`endif
        end
        if (bus.ordering_in_valid === 1'b1) begin
          if (run_b && m_beats < BN) begin
            for (int s = 7; s >= 0; s--) begin
              if (m_pushed < CN) begin
                mq.push_back(bus.ordering_in_data[s]);
                m_pushed++;
              end
            end
            m_beats++;
          end else begin
            e_ovf = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare and timing capture ----------------
  int n_wr = 0, first_wr = -1, done_rel = -1, first_perm = -1;

  initial begin : compare
    int rel;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("wr_en", bus.wr_en, e_en);
        if (e_en) begin
          check("wr_addr", bus.wr_addr, e_addr);
          check("wr_data", bus.wr_data, e_data);
        end
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("ovf", ovf, e_ovf);
        check("perm_err", perm_err, e_perm);
        rel = cyc - start_edge;
        if (rel == 0) begin
          n_wr = 0; first_wr = -1; done_rel = -1; first_perm = -1;
        end
        if (bus.wr_en === 1'b1) begin
          if (n_wr == 0) first_wr = rel;
          n_wr++;
        end
        if (done === 1'b1) done_rel = rel;
        if (perm_err === 1'b1 && first_perm < 0) first_perm = rel;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [7:0] tour [32];

  function automatic ordering_beat_t mk(input int i);
    ordering_beat_t b;
    for (int s = 0; s < 8; s++) b[s] = tour[8 * i + 7 - s];
    return b;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic arm_load();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_beat(input ordering_beat_t b);
    bus.ordering_in_valid = 1'b1;
    bus.ordering_in_data  = b;
    tick();
    bus.ordering_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy === 1'b1 && k < budget) begin tick(); k++; end
    if (busy !== 1'b0) begin
      n_chk++; n_fail++;
      $display("FAIL load_timeout: busy=%b after %0d cycles, required 0", busy, k);
    end
    repeat (2) tick();
  endtask

  task automatic identity_tour();
    for (int i = 0; i < 32; i++) tour[i] = 8'(i);
  endtask

  task automatic rand_load(input bit corrupt);
    int j;
    logic [7:0] t;
    for (int i = 0; i < 32; i++) tour[i] = (i < CN) ? 8'(i) : 8'd0;
    for (int i = CN - 1; i > 1; i--) begin
      j = int'($urandom_range(1, i));
      t = tour[i]; tour[i] = tour[j]; tour[j] = t;
    end
    if (corrupt) tour[$urandom_range(1, CN - 1)] = 8'($urandom_range(0, 40));
    arm_load();
    for (int i = 0; i < BN; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 6)) begin
          start = ($urandom_range(0, 4) == 0);
          tick();
        end
        start = 1'b0;
      end
      send_beat(mk(i));
    end
    if ($urandom_range(0, 3) == 0) send_beat(mk(0));
    wait_idle(100);
    if ($urandom_range(0, 2) == 0) begin
      send_beat(ordering_beat_t'({$urandom, $urandom}));
      tick();
    end
  endtask

  initial begin : stim
    int n2, f2, d2;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    bus.ordering_in_valid = 1'b0;  bus.ordering_in_data = '0;
    bus2.ordering_in_valid = 1'b0; bus2.ordering_in_data = '0;
    repeat (3) tick();
    check("reset wr_en", bus.wr_en, 0);
    check("reset wr_addr", bus.wr_addr, 0);
    check("reset wr_data", bus.wr_data, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ovf", ovf, 0);
    check("reset perm_err", perm_err, 0);
    #2 rst_n = 1'b1;
    repeat (2) tick();

    // Identity tour, back-to-back beats.
    identity_tour();
    arm_load();
    check("busy after start", busy, 1);
    for (int i = 0; i < BN; i++) send_beat(mk(i));
    wait_idle(60);
    check("t1 first write edge", first_wr, 2);
    check("t1 write count", n_wr, 31);
    check("t1 done edge", done_rel, 33);
    check("t1 ovf", ovf, 0);
    check("t1 perm_err", perm_err, 0);

    // Gap after the first beat stalls the writes by two cycles.
    arm_load();
    send_beat(mk(0));
    repeat (9) tick();
    for (int i = 1; i < BN; i++) send_beat(mk(i));
    wait_idle(80);
    check("t2 first write edge", first_wr, 2);
    check("t2 write count", n_wr, 31);
    check("t2 done edge", done_rel, 35);

    // Fifth beat is dropped and flags ovf.
    arm_load();
    for (int i = 0; i < BN; i++) send_beat(mk(i));
    send_beat(mk(0));
    check("t3 ovf after extra beat", ovf, 1);
    wait_idle(60);
    check("t3 write count", n_wr, 31);
    check("t3 done edge", done_rel, 33);
    arm_load();
    check("t3 ovf cleared by start", ovf, 0);
    for (int i = 0; i < BN; i++) send_beat(mk(i));
    wait_idle(60);
    send_beat(mk(1));
    check("t3 ovf from idle beat", ovf, 1);

    // Reset in the middle of a load.
    arm_load();
    for (int i = 0; i < BN; i++) send_beat(mk(i));
    repeat (5) tick();
    check("t4 writing before reset", bus.wr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4 wr_en in reset", bus.wr_en, 0);
    check("t4 wr_addr in reset", bus.wr_addr, 0);
    check("t4 wr_data in reset", bus.wr_data, 0);
    check("t4 busy in reset", busy, 0);
    check("t4 ovf in reset", ovf, 0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    arm_load();
    for (int i = 0; i < BN; i++) send_beat(mk(i));
    wait_idle(60);
    check("t4 reload write count", n_wr, 31);
    check("t4 reload done edge", done_rel, 33);

`ifdef ORDERING_CHECK_EN
    // Duplicate city 5 at address 9 and out-of-range city 31 at address 12.
    identity_tour();
    tour[9] = 8'd5;
    tour[12] = 8'd31;
    arm_load();
    for (int i = 0; i < BN; i++) send_beat(mk(i));
    wait_idle(60);
    check("t5 perm_err first edge", first_perm, 12);
    check("t5 perm_err held after done", perm_err, 1);
`endif

    // Randomized tours, gaps, extra beats, idle beats and corruption.
    for (int n = 0; n < 12; n++) rand_load($urandom_range(0, 3) == 0);

    // 32-city instance: four full beats, no partial beat.
    for (int i = 0; i < 32; i++) tour[i] = 8'(i);
    n2 = 0; f2 = -1; d2 = -1;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      bus2.ordering_in_valid = (k <= 4);
      bus2.ordering_in_data  = (k <= 4) ? mk(k - 1) : '0;
      tick();
      if (bus2.wr_en === 1'b1) begin
        check("dut32 wr_addr", bus2.wr_addr, 32'(n2 % 32));
        check("dut32 wr_data", bus2.wr_data, 32'(n2));
        if (n2 == 0) f2 = k;
        n2++;
      end
      if (done2 === 1'b1) d2 = k;
    end
    bus2.ordering_in_valid = 1'b0;
    check("dut32 first write edge", f2, 2);
    check("dut32 write count", n2, 32);
    check("dut32 done edge", d2, 34);
    check("dut32 ovf", ovf2, 0);
    check("dut32 busy", busy2, 0);
    check("dut32 perm_err", perm2, 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
